enc_param_ctrl: RTL

//  Sequences the rotary-encoder user interface of the synth: turns decoded encoder step pulses
//  and the encoder push-button into browse/edit/commit operations on a small bank of synth

---
 rtl/enc_param_pkg.sv | 31 +++
 rtl/enc_step_accel.sv | 39 +++
 rtl/enc_param_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/enc_param_pkg.sv
// Shared types and parameter tables for the encoder UI controller.
// Parameter slots: VOL, OCT, WAVE, TEMPO (index 0..3).
package enc_param_pkg;

  typedef enum logic [1:0] {
    BROWSE = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int unsigned STD_PARAMS = 4;
  localparam int unsigned STD_IDX_W  = 2;

  localparam int unsigned IDX_VOL   = 0;
  localparam int unsigned IDX_OCT   = 1;
  localparam int unsigned IDX_WAVE  = 2;
  localparam int unsigned IDX_TEMPO = 3;

  localparam int unsigned PARAM_MAX [STD_PARAMS] = '{31, 7, 3, 19};
  localparam int unsigned PARAM_RST [STD_PARAMS] = '{20, 4, 0, 10};

  // Slots beyond the standard table read as max 0 / reset 0.
  function automatic int unsigned param_max(input int unsigned i);
    return (i < STD_PARAMS) ? PARAM_MAX[i[STD_IDX_W-1:0]] : 0;
  endfunction

  function automatic int unsigned param_rst(input int unsigned i);
    return (i < STD_PARAMS) ? PARAM_RST[i[STD_IDX_W-1:0]] : 0;
  endfunction

endpackage

// File: rtl/enc_step_accel.sv
// Step-acceleration tracker: flags a step as "fast" when it follows a same-direction
// step within ACCEL_WIN cycles. Built only when ENC_ACCEL_EN is defined.
`ifdef ENC_ACCEL_EN
module enc_step_accel #(
  parameter int unsigned ACCEL_WIN = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic step_up,
  input  logic step_dn,
  output logic fast_c
);

  localparam int unsigned WIN_W = $clog2(ACCEL_WIN + 1);

  logic [WIN_W-1:0] win_cnt;
  logic             dir_up;
  logic             have_prev;

  // win_cnt holds cycles elapsed since the previous step, saturating at ACCEL_WIN.
  assign fast_c = have_prev & (win_cnt < WIN_W'(ACCEL_WIN)) & (step_up ? dir_up : ~dir_up);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      win_cnt   <= '0;
      dir_up    <= 1'b0;
      have_prev <= 1'b0;
    end else if (step_up || step_dn) begin
      win_cnt   <= WIN_W'(1);
      dir_up    <= step_up;
      have_prev <= 1'b1;
    end else if (win_cnt < WIN_W'(ACCEL_WIN)) begin
      win_cnt   <= win_cnt + WIN_W'(1);
    end
  end

endmodule
`endif

// File: rtl/enc_param_ctrl.sv
// Rotary-encoder UI sequencer: browse / edit / commit over the synth parameter bank.
// Optional step acceleration in EDIT when ENC_ACCEL_EN is defined.
module enc_param_ctrl
  import enc_param_pkg::*;
#(
  parameter int unsigned NUM_PARAMS  = 4,
  parameter int unsigned VAL_W       = 5,
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned ACCEL_WIN   = 2_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          step_up,
  input  logic                          step_dn,
  input  logic                          sel_btn,
  output logic                          mode_edit,
  output logic [$clog2(NUM_PARAMS)-1:0] param_idx,
  output logic [VAL_W-1:0]              edit_val,
  output logic                          wr_en,
  output logic [$clog2(NUM_PARAMS)-1:0] wr_addr,
  output logic [VAL_W-1:0]              wr_data,
  output logic [NUM_PARAMS*VAL_W-1:0]   cfg_vals
);

  localparam int unsigned IDX_W = $clog2(NUM_PARAMS);
  localparam int unsigned EXT_W = VAL_W + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  if (ACCEL_WIN == 0 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("enc_param_ctrl: ACCEL_WIN must be >= 1 and TIMEOUT_CYC >= 2");
  end

  state_t                      state_q, state_d;
  logic                        btn_q;
  logic [CNT_W-1:0]            idle_cnt, idle_cnt_d;
  logic [IDX_W-1:0]            idx_d, wr_addr_d;
  logic [VAL_W-1:0]            val_d, wr_data_d;
  logic                        mode_edit_d, wr_en_d;
  logic [NUM_PARAMS*VAL_W-1:0] cfg_d, rst_vals;

  logic [VAL_W-1:0] max_tbl [NUM_PARAMS];
  logic [VAL_W-1:0] shadow  [NUM_PARAMS];

  // Constant limit/reset tables and an unpacked view of the committed bank.
  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_tbl
    assign max_tbl[g]                  = VAL_W'(param_max(g));
    assign rst_vals[g*VAL_W +: VAL_W]  = VAL_W'(param_rst(g));
    assign shadow[g]                   = cfg_vals[g*VAL_W +: VAL_W];
  end

  // Input qualification: simultaneous up+dn cancel, a press swallows any step.
  logic press_c, up_c, dn_c;
  assign press_c = sel_btn & ~btn_q;
  assign up_c    = step_up & ~step_dn & ~press_c;
  assign dn_c    = step_dn & ~step_up & ~press_c;

  logic [EXT_W-1:0] step_mag_c;

`ifdef ENC_ACCEL_EN
  logic fast_c, accel_clr_c, edit_c;
  assign edit_c      = (state_q == EDIT);
  assign accel_clr_c = (state_q == BROWSE) & press_c;

  enc_step_accel #(
    .ACCEL_WIN (ACCEL_WIN)
  ) u_accel (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accel_clr_c),
    .step_up (up_c & edit_c),
    .step_dn (dn_c & edit_c),
    .fast_c  (fast_c)
  );

  assign step_mag_c = fast_c ? EXT_W'(4) : EXT_W'(1);
`else
  assign step_mag_c = EXT_W'(1);
`endif

  // Saturating value arithmetic, one bit wider than the value to catch over/underflow.
  logic [EXT_W-1:0] up_sum_c, dn_diff_c, max_ext_c;
  logic [VAL_W-1:0] val_up_c, val_dn_c;
  assign max_ext_c = {1'b0, max_tbl[param_idx]};
  assign up_sum_c  = {1'b0, edit_val} + step_mag_c;
  assign dn_diff_c = {1'b0, edit_val} - step_mag_c;
  assign val_up_c  = (up_sum_c > max_ext_c) ? max_tbl[param_idx] : up_sum_c[VAL_W-1:0];
  assign val_dn_c  = dn_diff_c[VAL_W] ? '0 : dn_diff_c[VAL_W-1:0];

  always_comb begin
    state_d    = state_q;
    idx_d      = param_idx;
    val_d      = edit_val;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    cfg_d      = cfg_vals;
    idle_cnt_d = idle_cnt;

    unique case (state_q)
      BROWSE: begin
        idle_cnt_d = '0;
        if (press_c) begin
          state_d = EDIT;
          val_d   = shadow[param_idx];
        end else begin
          if (up_c) begin
            idx_d = (param_idx == IDX_W'(NUM_PARAMS - 1)) ? '0 : param_idx + IDX_W'(1);
          end else if (dn_c) begin
            idx_d = (param_idx == '0) ? IDX_W'(NUM_PARAMS - 1) : param_idx - IDX_W'(1);
          end
          val_d = shadow[idx_d];
        end
      end

      EDIT: begin
        if (press_c) begin
          state_d    = COMMIT;
          wr_en_d    = 1'b1;
          wr_addr_d  = param_idx;
          wr_data_d  = edit_val;
          idle_cnt_d = '0;
        end else if (up_c) begin
          val_d      = val_up_c;
          idle_cnt_d = '0;
        end else if (dn_c) begin
          val_d      = val_dn_c;
          idle_cnt_d = '0;
        end else if (idle_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d    = BROWSE;
          val_d      = shadow[param_idx];
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt + CNT_W'(1);
        end
      end

      COMMIT: begin
        state_d = BROWSE;
        for (int i = 0; i < NUM_PARAMS; i++) begin
          if (IDX_W'(i) == param_idx) cfg_d[i*VAL_W +: VAL_W] = edit_val;
        end
      end

      default: state_d = BROWSE;
    endcase

    mode_edit_d = (state_d != BROWSE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= BROWSE;
      btn_q     <= 1'b0;
      idle_cnt  <= '0;
      param_idx <= '0;
      edit_val  <= rst_vals[VAL_W-1:0];
      mode_edit <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cfg_vals  <= rst_vals;
    end else begin
      state_q   <= state_d;
      btn_q     <= sel_btn;
      idle_cnt  <= idle_cnt_d;
      param_idx <= idx_d;
      edit_val  <= val_d;
      mode_edit <= mode_edit_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      cfg_vals  <= cfg_d;
    end
  end

endmodule
